pix_adjust_pipe: RTL and testbench

Parametrised, pipelined per-channel brightness/contrast adjuster for the camera-to-VGA pixel path. It sits between the camera-side pixel stream and the frame store. It generalises fixed RGB565 key-driven adjustment to arbitrary channel widths, gain/offset limits and a valid/ready stream. New settings are latched only at frame boundaries, so a frame is never split between two settings.

---
 rtl/pix_adj_pkg.sv | 48 ++++
 rtl/pix_adj_chan.sv | 65 ++++++
 rtl/pix_adjust_pipe.sv | 196 +++++++++++++++++++
 tb/tb_pix_adjust_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_adj_pkg.sv
// Shared constants and helpers for the pixel brightness/contrast pipeline.
// Colour-bar constants are consumed only when PIX_TESTPAT_EN is defined.
package pix_adj_pkg;

    localparam int MID8   = 128;
    localparam int ACC_W  = 18;
    localparam int PROD_W = ACC_W;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic int gain_one(input int frac);
        return 1 << frac;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
        logic [7:0] r;
        if (v < 0)
            r = 8'd0;
        else if (v > 255)
            r = 8'hFF;
        else
            r = v[7:0];
        return r;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pix_adj_chan.sv
// One colour channel of the adjuster: expand to 8 bits, centre, scale by
// gain, add brightness, clamp and truncate back to CW bits over 3 stages.
module pix_adj_chan
    import pix_adj_pkg::*;
#(
    parameter int CW        = 5,
    parameter int GAIN_FRAC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CW-1:0]       x,
    input  logic [7:0]          gain,
    input  logic signed [7:0]   bri,
    output logic [CW-1:0]       y
);

    localparam logic signed [ACC_W-1:0] MID_S = ACC_W'(MID8);

    logic [8*CW-1:0]          rep;
    logic [7:0]               e;
    logic signed [ACC_W-1:0]  d_c;
    logic signed [ACC_W-1:0]  g_ext;
    logic signed [ACC_W-1:0]  s_c;
    logic [7:0]               y8;

    logic signed [ACC_W-1:0]  d1;
    logic [7:0]               g1;
    logic signed [7:0]        b1;
    logic signed [PROD_W-1:0] p2;
    logic signed [7:0]        b2;
    logic [CW-1:0]            y3;

    // Repeating the code and keeping the top 8 bits replicates MSBs into the LSBs.
    always_comb begin
        rep   = {8{x}};
        e     = rep[8*CW-1 -: 8];
        d_c   = $signed({{(ACC_W-8){1'b0}}, e}) - MID_S;
        g_ext = $signed({{(ACC_W-8){1'b0}}, g1});
        s_c   = (p2 >>> GAIN_FRAC) + MID_S + $signed({{(ACC_W-8){b2[7]}}, b2});
        y8    = clamp8(s_c);
    end

    // The settings ride along with the data so a frame change never mixes values.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            g1 <= '0;
            b1 <= '0;
            p2 <= '0;
            b2 <= '0;
            y3 <= '0;
        end else if (en) begin
            d1 <= d_c;
            g1 <= gain;
            b1 <= bri;
            p2 <= d1 * g_ext;
            b2 <= b1;
            y3 <= y8[7 -: CW];
        end
    end

    assign y = y3;

endmodule

// File: rtl/pix_adjust_pipe.sv
// Pipelined per-channel brightness/contrast adjuster with frame-latched settings.
// Optional colour-bar generator enabled by defining PIX_TESTPAT_EN.
module pix_adjust_pipe
    import pix_adj_pkg::*;
#(
    parameter int R_W       = 5,
    parameter int G_W       = 6,
    parameter int B_W       = 5,
    parameter int GAIN_FRAC = 4,
    parameter int GAIN_MIN  = 4,
    parameter int GAIN_MAX  = 64,
    parameter int BRI_MAX   = 96,
    parameter int BRI_STEP  = 8,
    parameter int GAIN_STEP = 2,
    parameter int H_ACTIVE  = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bri_up,
    input  logic                     bri_dn,
    input  logic                     con_up,
    input  logic                     con_dn,
`ifdef PIX_TESTPAT_EN
    input  logic                     test_en,
`endif
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [R_W+G_W+B_W-1:0]   s_data,
    input  logic                     s_sof,
    input  logic                     s_eol,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [R_W+G_W+B_W-1:0]   m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic signed [7:0]        bri_cur,
    output logic [7:0]               gain_cur
);

    localparam int PIX_W = R_W + G_W + B_W;
    localparam logic [7:0]        G_ONE  = 8'(gain_one(GAIN_FRAC));
    localparam logic signed [9:0] BRI_HI = 10'(BRI_MAX);
    localparam logic signed [9:0] BRI_LO = -10'(BRI_MAX);
    localparam logic signed [9:0] BSTEP  = 10'(BRI_STEP);
    localparam logic signed [9:0] G_LO   = 10'(GAIN_MIN);
    localparam logic signed [9:0] G_HI   = 10'(GAIN_MAX);
    localparam logic signed [9:0] GSTEP  = 10'(GAIN_STEP);

    logic                adv;
    logic                acc;
    logic                latch_now;
    logic signed [7:0]   bri_pend;
    logic [7:0]          gain_pend;
    logic signed [9:0]   bri_w;
    logic signed [9:0]   gain_w;
    logic signed [7:0]   bri_eff;
    logic [7:0]          gain_eff;
    logic [PIX_W-1:0]    pix;
    logic                v1, v2, v3;
    logic                sof1, sof2, sof3;
    logic                eol1, eol2, eol3;
    logic [R_W-1:0]      r_y;
    logic [G_W-1:0]      g_y;
    logic [B_W-1:0]      b_y;

    assign adv     = !v3 || m_ready;
    assign s_ready = adv;
    assign acc     = s_valid && adv;
    assign m_valid = v3;
    assign m_sof   = sof3;
    assign m_eol   = eol3;
    assign m_data  = {r_y, g_y, b_y};

    // Pending settings step and saturate; opposing pulses cancel.
    always_comb begin
        bri_w  = {{2{bri_pend[7]}}, bri_pend};
        gain_w = $signed({2'b00, gain_pend});
        if (bri_up && !bri_dn)
            bri_w = bri_w + BSTEP;
        else if (bri_dn && !bri_up)
            bri_w = bri_w - BSTEP;
        if (bri_w > BRI_HI)
            bri_w = BRI_HI;
        else if (bri_w < BRI_LO)
            bri_w = BRI_LO;
        if (con_up && !con_dn)
            gain_w = gain_w + GSTEP;
        else if (con_dn && !con_up)
            gain_w = gain_w - GSTEP;
        if (gain_w > G_HI)
            gain_w = G_HI;
        else if (gain_w < G_LO)
            gain_w = G_LO;
    end

    // The sof beat itself must already see the newly latched values.
    always_comb begin
        latch_now = acc && s_sof;
        bri_eff   = latch_now ? bri_pend  : bri_cur;
        gain_eff  = latch_now ? gain_pend : gain_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bri_pend  <= '0;
            gain_pend <= G_ONE;
            bri_cur   <= '0;
            gain_cur  <= G_ONE;
        end else begin
            bri_pend  <= bri_w[7:0];
            gain_pend <= gain_w[7:0];
            if (latch_now) begin
                bri_cur  <= bri_pend;
                gain_cur <= gain_pend;
            end
        end
    end

`ifdef PIX_TESTPAT_EN
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_use;
    logic [2:0]       bar;
    logic [23:0]      rgb;
    int               bar_i;

    // A sof beat always sits in column 0, even if the previous line lacked eol.
    always_comb begin
        col_use = s_sof ? '0 : col;
        bar_i   = int'(col_use) / BAR_W;
        bar     = (bar_i > 7) ? 3'd7 : 3'(bar_i);
        rgb     = bar_rgb(bar);
        pix     = test_en ? {rgb[23 -: R_W], rgb[15 -: G_W], rgb[7 -: B_W]} : s_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            col <= '0;
        else if (acc)
            col <= s_eol ? '0 : col_use + COL_W'(1);
    end
`else
    assign pix = s_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3}       <= '0;
            {sof1, sof2, sof3} <= '0;
            {eol1, eol2, eol3} <= '0;
        end else if (adv) begin
            v1   <= s_valid;
            v2   <= v1;
            v3   <= v2;
            sof1 <= s_sof && s_valid;
            sof2 <= sof1;
            sof3 <= sof2;
            eol1 <= s_eol && s_valid;
            eol2 <= eol1;
            eol3 <= eol2;
        end
    end

    pix_adj_chan #(.CW(R_W), .GAIN_FRAC(GAIN_FRAC)) u_chan_r (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .x    (pix[PIX_W-1 -: R_W]),
        .gain (gain_eff),
        .bri  (bri_eff),
        .y    (r_y)
    );

    pix_adj_chan #(.CW(G_W), .GAIN_FRAC(GAIN_FRAC)) u_chan_g (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .x    (pix[G_W+B_W-1 -: G_W]),
        .gain (gain_eff),
        .bri  (bri_eff),
        .y    (g_y)
    );

    pix_adj_chan #(.CW(B_W), .GAIN_FRAC(GAIN_FRAC)) u_chan_b (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .x    (pix[B_W-1:0]),
        .gain (gain_eff),
        .bri  (bri_eff),
        .y    (b_y)
    );

endmodule

// File: tb/tb_pix_adjust_pipe.sv
// Self-checking bench for pix_adjust_pipe in its default RGB565 configuration.
module tb_pix_adjust_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        bri_up, bri_dn, con_up, con_dn;
    logic        s_valid, s_ready, s_sof, s_eol;
    logic [15:0] s_data;
    logic        m_valid, m_ready, m_sof, m_eol;
    logic [15:0] m_data;
    logic [7:0]  bri_cur, gain_cur;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] expq[$];

    typedef struct {
        int          bu;
        int          bd;
        int          cu;
        int          both;
        logic        sof;
        logic        eol;
        logic [15:0] din;
        logic [15:0] exp_data;
        logic [7:0]  exp_bri;
        logic [7:0]  exp_gain;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    pix_adjust_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .bri_up   (bri_up),
        .bri_dn   (bri_dn),
        .con_up   (con_up),
        .con_dn   (con_dn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .s_eol    (s_eol),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .bri_cur  (bri_cur),
        .gain_cur (gain_cur)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic bu, input logic bd, input logic cu, input logic cd);
        bri_up = bu; bri_dn = bd; con_up = cu; con_dn = cd;
        tick();
        bri_up = 0; bri_dn = 0; con_up = 0; con_dn = 0;
    endtask

    function automatic int chan_model(input int x, input int cw, input int g, input int b);
        int e, d, y;
        e = (x << (8 - cw)) | (x >> (2 * cw - 8));
        d = ((e - 128) * g) >>> 4;
        y = d + 128 + b;
        if (y < 0) y = 0;
        if (y > 255) y = 255;
        return y >> (8 - cw);
    endfunction

    function automatic logic [15:0] model_pix(input logic [15:0] p, input int g, input int b);
        int r, gg, bb;
        r  = chan_model(int'(p[15:11]), 5, g, b);
        gg = chan_model(int'(p[10:5]), 6, g, b);
        bb = chan_model(int'(p[4:0]), 5, g, b);
        return 16'((r << 11) | (gg << 5) | bb);
    endfunction

    // One isolated beat on an idle pipe: checks latency, data and live settings.
    task automatic apply_stimulus(input vec_t v, input int idx);
        repeat (v.bu) pulse(1, 0, 0, 0);
        repeat (v.bd) pulse(0, 1, 0, 0);
        repeat (v.cu) pulse(0, 0, 1, 0);
        if (v.both != 0) begin
            pulse(1, 1, 1, 1);
            pulse(1, 1, 1, 1);
        end
        s_valid = 1; s_data = v.din; s_sof = v.sof; s_eol = v.eol;
        check_output($sformatf("s_ready[%0d]", idx), 32'(s_ready), 32'd1);
        tick();
        s_valid = 0; s_sof = 0; s_eol = 0;
        check_output($sformatf("bri_cur[%0d]", idx), 32'(bri_cur), 32'(v.exp_bri));
        check_output($sformatf("gain_cur[%0d]", idx), 32'(gain_cur), 32'(v.exp_gain));
        tick();
        check_output($sformatf("early_valid[%0d]", idx), 32'(m_valid), 32'd0);
        tick();
        check_output($sformatf("m_valid[%0d]", idx), 32'(m_valid), 32'd1);
        check_output($sformatf("m_data[%0d]", idx), 32'(m_data), 32'(v.exp_data));
        check_output($sformatf("m_sof[%0d]", idx), 32'(m_sof), 32'(v.sof));
        check_output($sformatf("m_eol[%0d]", idx), 32'(m_eol), 32'(v.eol));
        tick();
    endtask

    task automatic run_backpressure();
        fork
            begin
                logic        accepted;
                int          waited;
                logic [15:0] d;
                for (int i = 0; i < 1000; i++) begin
                    d = 16'($urandom);
                    s_valid = 1; s_data = d; s_sof = (i == 0); s_eol = (i % 40 == 39);
                    accepted = 0;
                    waited = 0;
                    while (!accepted && waited < 100) begin
                        @(negedge clk);
                        accepted = s_ready;
                        tick();
                        waited++;
                    end
                    if (!accepted) begin
                        check_output("bp_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    expq.push_back(model_pix(d, 12, 8));
                end
                s_valid = 0; s_sof = 0; s_eol = 0;
            end
            begin
                int          got;
                int          cycles;
                logic        stalled;
                logic [15:0] held;
                logic [15:0] want;
                got = 0; cycles = 0; stalled = 0; held = '0;
                while (got < 1000 && cycles < 6000) begin
                    @(negedge clk);
                    cycles++;
                    if (stalled) begin
                        check_output("bp_hold_valid", 32'(m_valid), 32'd1);
                        check_output("bp_hold_data", 32'(m_data), 32'(held));
                    end
                    stalled = 0;
                    if (m_valid && m_ready) begin
                        if (expq.size() == 0) begin
                            check_output("bp_unexpected_beat", 32'(m_data), 32'hFFFFFFFF);
                        end else begin
                            want = expq.pop_front();
                            check_output($sformatf("bp_data[%0d]", got), 32'(m_data), 32'(want));
                        end
                        got++;
                    end else if (m_valid) begin
                        stalled = 1;
                        held = m_data;
                    end
                    tick();
                    m_ready = 1'($urandom % 2);
                end
                check_output("bp_beat_count", 32'(got), 32'd1000);
            end
        join
        m_ready = 1;
        repeat (4) tick();
        check_output("bp_no_extra_valid", 32'(m_valid), 32'd0);
        check_output("bp_queue_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 0,  0, 0, 1'b1, 1'b0, 16'hF800, 16'hF800, 8'h00, 8'h10};
        vecs[1]  = '{0, 0,  0, 0, 1'b0, 1'b0, 16'h07E0, 16'h07E0, 8'h00, 8'h10};
        vecs[2]  = '{0, 0,  0, 0, 1'b0, 1'b0, 16'h001F, 16'h001F, 8'h00, 8'h10};
        vecs[3]  = '{0, 0,  0, 0, 1'b0, 1'b1, 16'h1234, 16'h1234, 8'h00, 8'h10};
        vecs[4]  = '{2, 0,  0, 0, 1'b1, 1'b0, 16'h0400, 16'h1482, 8'h10, 8'h10};
        vecs[5]  = '{1, 0,  0, 0, 1'b0, 1'b0, 16'h0400, 16'h1482, 8'h10, 8'h10};
        vecs[6]  = '{0, 3,  8, 0, 1'b1, 1'b0, 16'h0400, 16'h0420, 8'h00, 8'h20};
        vecs[7]  = '{0, 0,  0, 0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 8'h00, 8'h20};
        vecs[8]  = '{0, 20, 0, 0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'hA0, 8'h20};
        vecs[9]  = '{0, 2,  0, 0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 8'hA0, 8'h20};
        vecs[10] = '{0, 0, 20, 0, 1'b1, 1'b0, 16'h0400, 16'h0140, 8'hA0, 8'h40};
        vecs[11] = '{0, 0,  0, 1, 1'b1, 1'b0, 16'h0400, 16'h0140, 8'hA0, 8'h40};

        rst = 1; bri_up = 0; bri_dn = 0; con_up = 0; con_dn = 0;
        s_valid = 0; s_data = '0; s_sof = 0; s_eol = 0; m_ready = 1;
        repeat (2) tick();
        check_output("reset_m_valid", 32'(m_valid), 32'd0);
        check_output("reset_m_data", 32'(m_data), 32'd0);
        check_output("reset_bri", 32'(bri_cur), 32'd0);
        check_output("reset_gain", 32'(gain_cur), 32'd16);
        rst = 0;
        tick();
        check_output("reset_s_ready", 32'(s_ready), 32'd1);

        for (int i = 0; i < 12; i++)
            apply_stimulus(vecs[i], i);

        rst = 1;
        tick();
        rst = 0;
        check_output("rst2_gain", 32'(gain_cur), 32'd16);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        run_backpressure();
        check_output("bp_bri_cur", 32'(bri_cur), 32'd8);
        check_output("bp_gain_cur", 32'(gain_cur), 32'd12);

        // Three beats in flight, then reset: nothing stale may emerge.
        begin
            logic seen;
            m_ready = 1;
            for (int i = 0; i < 3; i++) begin
                s_valid = 1; s_data = 16'h5A5A + 16'(i); s_sof = (i == 0); s_eol = 0;
                tick();
            end
            s_valid = 0; s_sof = 0;
            check_output("mid_inflight_valid", 32'(m_valid), 32'd1);
            rst = 1;
            tick();
            check_output("mid_rst_m_valid", 32'(m_valid), 32'd0);
            check_output("mid_rst_bri", 32'(bri_cur), 32'd0);
            check_output("mid_rst_gain", 32'(gain_cur), 32'd16);
            rst = 0;
            tick();
            check_output("mid_rst_s_ready", 32'(s_ready), 32'd1);
            seen = 0;
            repeat (6) begin
                if (m_valid) seen = 1;
                tick();
            end
            check_output("mid_rst_no_stale", 32'(seen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
